// File: rtl/otter_pipe_pkg.sv
// Shared types and constants for the Otter pipeline hazard controller.
package otter_pipe_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WAIT_CTR_W = 16;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        HZ_RUN,
        HZ_MEM_WAIT
    } hz_state_t;

endpackage

// File: rtl/hazard_cmp.sv
// Register-match comparator: hit when the producer writes a nonzero register read by the consumer.
module hazard_cmp
    import otter_pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src_addr_i,
    input  logic [REG_ADDR_W-1:0] dst_addr_i,
    input  logic                  reg_write_i,
    output logic                  hit_o
);

    assign hit_o = reg_write_i && (src_addr_i != '0) && (src_addr_i == dst_addr_i);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Otter 5-stage pipeline sequencer: stalls, flushes, forwarding selects, perf counters, mem timeout.
// Optional operand forwarding is enabled by defining PIPE_FORWARDING_EN.
module pipeline_hazard_ctrl
    import otter_pipe_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [REG_ADDR_W-1:0] rs1_addr_D,
    input  logic [REG_ADDR_W-1:0] rs2_addr_D,
    input  logic                  rs1_used_D,
    input  logic                  rs2_used_D,
    input  logic [REG_ADDR_W-1:0] rs1_addr_E,
    input  logic [REG_ADDR_W-1:0] rs2_addr_E,
    input  logic [REG_ADDR_W-1:0] rd_addr_E,
    input  logic                  regWrite_E,
    input  logic                  memRead2_E,
    input  logic [REG_ADDR_W-1:0] rd_addr_M,
    input  logic                  regWrite_M,
    input  logic [REG_ADDR_W-1:0] rd_addr_W,
    input  logic                  regWrite_W,
    input  logic                  redirect_E,
    input  logic                  dmem_req_M,
    input  logic                  dmem_ready,
    output logic                  pc_en,
    output logic                  fd_en,
    output logic                  de_en,
    output logic                  em_en,
    output logic                  mw_en,
    output logic                  fd_flush,
    output logic                  de_flush,
    output logic [1:0]            fwdA_sel,
    output logic [1:0]            fwdB_sel,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic                  mem_err
);

    localparam logic [WAIT_CTR_W-1:0] TIMEOUT_V = WAIT_CTR_W'(MEM_TIMEOUT);

    hz_state_t             state_q, state_d;
    logic [WAIT_CTR_W-1:0] wait_ctr_q, wait_ctr_d;
    logic                  mem_err_q, mem_err_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

    logic     mem_wait, data_hazard, redirect_fire;
    logic     hit1_e, hit2_e;
    logic     pc_run, fd_run, de_run, em_run, mw_run, fdf_run, def_run;
    fwd_sel_t fwd_a, fwd_b;

    assign mem_wait = dmem_req_M & ~dmem_ready;

    hazard_cmp u_cmp_d1_e (.src_addr_i(rs1_addr_D), .dst_addr_i(rd_addr_E), .reg_write_i(regWrite_E), .hit_o(hit1_e));
    hazard_cmp u_cmp_d2_e (.src_addr_i(rs2_addr_D), .dst_addr_i(rd_addr_E), .reg_write_i(regWrite_E), .hit_o(hit2_e));

`ifdef PIPE_FORWARDING_EN
    logic hit_a_m, hit_a_w, hit_b_m, hit_b_w;

    hazard_cmp u_cmp_ea_m (.src_addr_i(rs1_addr_E), .dst_addr_i(rd_addr_M), .reg_write_i(regWrite_M), .hit_o(hit_a_m));
    hazard_cmp u_cmp_ea_w (.src_addr_i(rs1_addr_E), .dst_addr_i(rd_addr_W), .reg_write_i(regWrite_W), .hit_o(hit_a_w));
    hazard_cmp u_cmp_eb_m (.src_addr_i(rs2_addr_E), .dst_addr_i(rd_addr_M), .reg_write_i(regWrite_M), .hit_o(hit_b_m));
    hazard_cmp u_cmp_eb_w (.src_addr_i(rs2_addr_E), .dst_addr_i(rd_addr_W), .reg_write_i(regWrite_W), .hit_o(hit_b_w));

    assign data_hazard = memRead2_E & ((rs1_used_D & hit1_e) | (rs2_used_D & hit2_e));

    // The younger M-stage result wins over W when both match.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (hit_a_m)      fwd_a = FWD_MEM;
        else if (hit_a_w) fwd_a = FWD_WB;
        if (hit_b_m)      fwd_b = FWD_MEM;
        else if (hit_b_w) fwd_b = FWD_WB;
    end
`else
    logic hit1_m, hit1_w, hit2_m, hit2_w;
    logic unused_fwd_inputs;

    hazard_cmp u_cmp_d1_m (.src_addr_i(rs1_addr_D), .dst_addr_i(rd_addr_M), .reg_write_i(regWrite_M), .hit_o(hit1_m));
    hazard_cmp u_cmp_d1_w (.src_addr_i(rs1_addr_D), .dst_addr_i(rd_addr_W), .reg_write_i(regWrite_W), .hit_o(hit1_w));
    hazard_cmp u_cmp_d2_m (.src_addr_i(rs2_addr_D), .dst_addr_i(rd_addr_M), .reg_write_i(regWrite_M), .hit_o(hit2_m));
    hazard_cmp u_cmp_d2_w (.src_addr_i(rs2_addr_D), .dst_addr_i(rd_addr_W), .reg_write_i(regWrite_W), .hit_o(hit2_w));

    // Without bypass paths, D waits until its producer has left W.
    assign data_hazard = (rs1_used_D & (hit1_e | hit1_m | hit1_w)) |
                         (rs2_used_D & (hit2_e | hit2_m | hit2_w));
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
    assign unused_fwd_inputs = ^{rs1_addr_E, rs2_addr_E, memRead2_E};
`endif

    always_comb begin
        pc_run        = 1'b1;
        fd_run        = 1'b1;
        de_run        = 1'b1;
        em_run        = 1'b1;
        mw_run        = 1'b1;
        fdf_run       = 1'b0;
        def_run       = 1'b0;
        redirect_fire = 1'b0;
        if (mem_wait) begin
            pc_run = 1'b0;
            fd_run = 1'b0;
            de_run = 1'b0;
            em_run = 1'b0;
            mw_run = 1'b0;
        end else if (redirect_E) begin
            fdf_run       = 1'b1;
            def_run       = 1'b1;
            redirect_fire = 1'b1;
        end else if (data_hazard) begin
            pc_run  = 1'b0;
            fd_run  = 1'b0;
            def_run = 1'b1;
        end
    end

    // Reset gating stays on the output side so RST_N never feeds flop data.
    assign pc_en    = RST_N & pc_run;
    assign fd_en    = RST_N & fd_run;
    assign de_en    = RST_N & de_run;
    assign em_en    = RST_N & em_run;
    assign mw_en    = RST_N & mw_run;
    assign fd_flush = ~RST_N | fdf_run;
    assign de_flush = ~RST_N | def_run;
    assign fwdA_sel = RST_N ? fwd_a : FWD_RF;
    assign fwdB_sel = RST_N ? fwd_b : FWD_RF;

    always_comb begin
        state_d    = state_q;
        wait_ctr_d = wait_ctr_q;
        mem_err_d  = mem_err_q;
        unique case (state_q)
            HZ_RUN: begin
                if (mem_wait) begin
                    state_d    = HZ_MEM_WAIT;
                    wait_ctr_d = '0;
                end
            end
            HZ_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = HZ_RUN;
                end else begin
                    if (wait_ctr_q != '1) wait_ctr_d = wait_ctr_q + WAIT_CTR_W'(1);
                    if (wait_ctr_d == TIMEOUT_V) mem_err_d = 1'b1;
                end
            end
            default: state_d = HZ_RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_run && stall_cnt_q != '1)       stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (redirect_fire && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= HZ_RUN;
            wait_ctr_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_ctr_q  <= wait_ctr_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign mem_err   = mem_err_q;

endmodule
